// File: rtl/tx_rd_req_engine.sv
// Splits read jobs into MRd TLPs on the TRN TX interface and manages the tag pool.
// Optional RD_REQ_32BIT_HDR_EN: emit 3DW MRd headers for addresses below 4 GB.
module tx_rd_req_engine #(
    parameter int TAG_WIDTH     = 5,
    parameter int MAX_RD_REQ_DW = 128
) (
    input  logic                 trn_clk,
    input  logic                 reset_n,
    output logic [63:0]          trn_td,
    output logic [7:0]           trn_trem_n,
    output logic                 trn_tsof_n,
    output logic                 trn_teof_n,
    output logic                 trn_tsrc_rdy_n,
    input  logic                 trn_tdst_rdy_n,
    input  logic [3:0]           trn_tbuf_av,
    input  logic [15:0]          cfg_completer_id,
    input  logic                 rd_req,
    input  logic [63:0]          rd_addr,
    input  logic [12:0]          rd_len_dw,
    output logic                 rd_req_ack,
    output logic                 rd_busy,
    output logic                 rd_done,
    input  logic                 tag_release,
    input  logic [TAG_WIDTH-1:0] tag_release_tag,
    output logic [TAG_WIDTH:0]   tags_in_flight,
    input  logic                 my_turn,
    output logic                 driving_interface
);

    localparam int POOL = 1 << TAG_WIDTH;
    localparam logic [10:0] MAX_DW   = 11'(MAX_RD_REQ_DW);
    localparam logic [10:0] MRRS_MSK = 11'(MAX_RD_REQ_DW - 1);

    typedef enum logic [4:0] {
        IDLE     = 5'b00001,
        LATCH    = 5'b00010,
        HDR      = 5'b00100,
        ADDR     = 5'b01000,
        WAIT_EOF = 5'b10000
    } state_t;

    state_t state, next_state;

    logic [63:0]          job_addr;
    logic [12:0]          remaining;
    logic [10:0]          tlp_len;
    logic [TAG_WIDTH-1:0] cur_tag;
    logic [POOL-1:0]      tag_busy;

    logic [10:0]          dw_off;
    logic [10:0]          room;
    logic [10:0]          next_len;
    logic                 free_any;
    logic [TAG_WIDTH-1:0] free_idx;
    logic                 rel_valid;
    logic                 accept;
    logic                 job_take;
    logic                 start;
    logic                 alloc;
    logic                 eof_acc;
    logic                 last_tlp;
    logic                 use3dw;
    logic [31:0]          hdr_dw0;
    logic [31:0]          hdr_dw1;
    logic [63:0]          addr_beat;
    logic [7:0]           addr_trem;
    logic                 unused_inputs;

    assign unused_inputs = ^{trn_tbuf_av[3:1], rd_addr[1:0]};

    // Length is bounded by the distance to the next MRRS-aligned boundary, which
    // also keeps every TLP inside a 4 KB page since MRRS divides 1024 DWs.
    assign dw_off   = job_addr[12:2] & MRRS_MSK;
    assign room     = MAX_DW - dw_off;
    assign next_len = (remaining < 13'(room)) ? 11'(remaining) : room;

    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = POOL - 1; i >= 0; i--) begin
            if (!tag_busy[i]) begin
                free_any = 1'b1;
                free_idx = TAG_WIDTH'(i);
            end
        end
    end

    assign rel_valid = tag_release && tag_busy[tag_release_tag];
    assign accept    = !trn_tdst_rdy_n;
    assign job_take  = rd_req && !rd_busy;
    assign start     = rd_busy && my_turn && trn_tbuf_av[0] && accept && free_any;
    assign alloc     = (state == IDLE) && start;
    assign eof_acc   = ((state == ADDR) || (state == WAIT_EOF)) && accept;
    assign last_tlp  = (remaining == 13'(tlp_len));

`ifdef RD_REQ_32BIT_HDR_EN
    assign use3dw = (job_addr[63:32] == 32'h0);
`else
    assign use3dw = 1'b0;
`endif

    assign hdr_dw0   = {1'b0, (use3dw ? 2'b00 : 2'b01), 5'b00000, 8'h00, 6'b000000, tlp_len[9:0]};
    assign hdr_dw1   = {cfg_completer_id, 8'(cur_tag), ((tlp_len > 11'd1) ? 4'hF : 4'h0), 4'hF};
    assign addr_beat = use3dw ? {job_addr[31:0], 32'h0} : job_addr;
    assign addr_trem = use3dw ? 8'h0F : 8'h00;

    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state        = state;
        trn_td            = '0;
        trn_trem_n        = 8'hFF;
        trn_tsof_n        = 1'b1;
        trn_teof_n        = 1'b1;
        trn_tsrc_rdy_n    = 1'b1;
        driving_interface = 1'b0;
        unique case (state)
            IDLE: begin
                if (job_take) begin
                    next_state = LATCH;
                end else if (start) begin
                    next_state = HDR;
                end
            end
            LATCH: next_state = IDLE;
            HDR: begin
                trn_td            = {hdr_dw0, hdr_dw1};
                trn_trem_n        = 8'h00;
                trn_tsof_n        = 1'b0;
                trn_tsrc_rdy_n    = 1'b0;
                driving_interface = 1'b1;
                if (accept) begin
                    next_state = ADDR;
                end
            end
            ADDR, WAIT_EOF: begin
                trn_td            = addr_beat;
                trn_trem_n        = addr_trem;
                trn_teof_n        = 1'b0;
                trn_tsrc_rdy_n    = 1'b0;
                driving_interface = 1'b1;
                next_state        = accept ? IDLE : WAIT_EOF;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_req_ack <= 1'b0;
            rd_done    <= 1'b0;
            rd_busy    <= 1'b0;
        end else begin
            rd_req_ack <= (state == IDLE) && job_take;
            rd_done    <= eof_acc && last_tlp;
            if ((state == IDLE) && job_take) begin
                rd_busy <= 1'b1;
            end else if (eof_acc && last_tlp) begin
                rd_busy <= 1'b0;
            end
        end
    end

    // An allocated tag is always free beforehand, so it never collides with a valid release.
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_busy       <= '0;
            tags_in_flight <= '0;
        end else begin
            for (int i = 0; i < POOL; i++) begin
                if (alloc && (free_idx == TAG_WIDTH'(i))) begin
                    tag_busy[i] <= 1'b1;
                end else if (rel_valid && (tag_release_tag == TAG_WIDTH'(i))) begin
                    tag_busy[i] <= 1'b0;
                end
            end
            case ({alloc, rel_valid})
                2'b10:   tags_in_flight <= tags_in_flight + 1'b1;
                2'b01:   tags_in_flight <= tags_in_flight - 1'b1;
                default: tags_in_flight <= tags_in_flight;
            endcase
        end
    end

    always_ff @(posedge trn_clk) begin
        if ((state == IDLE) && job_take) begin
            job_addr  <= {rd_addr[63:2], 2'b00};
            remaining <= rd_len_dw;
        end else if (eof_acc) begin
            job_addr  <= job_addr + {51'h0, tlp_len, 2'b00};
            remaining <= remaining - 13'(tlp_len);
        end
        if (alloc) begin
            tlp_len <= next_len;
            cur_tag <= free_idx;
        end
    end

endmodule
